// File: rtl/pc_gen_pkg.sv
// Shared types and default vectors for the fetch PC generator.
// Vectors are byte addresses; the PC itself is a word address.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_3000;
    localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/pc_gen_epc.sv
// Saved-exception-PC register; captures the current PC when a trap is taken.
// Only holds state when PC_GEN_EPC_EN is defined, otherwise reads as zero.
module pc_gen_epc #(
    parameter int PW = 30
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_i,
    input  logic [PW-1:0] pc_i,
    output logic [PW-1:0] epc_o
);

`ifdef PC_GEN_EPC_EN
    logic [PW-1:0] epc_q;
    logic [PW-1:0] epc_d;

    always_comb begin
        epc_d = epc_q;
        if (load_i) begin
            epc_d = pc_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            epc_q <= '0;
        end else begin
            epc_q <= epc_d;
        end
    end

    assign epc_o = epc_q;
`else
    logic unused_epc_in;
    assign unused_epc_in = load_i ^ (^pc_i) ^ CLK ^ RST;
    assign epc_o         = '0;
`endif

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, trap/eret/branch redirects, 1-cycle update.
// Optional exception-return support is enabled with the PC_GEN_EPC_EN macro.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int          AW        = 32,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] TRAP_VEC  = TRAP_VEC_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          stall_i,
    input  logic          br_valid_i,
    input  logic [AW-3:0] br_target_i,
    input  logic          trap_i,
    input  logic          eret_i,
    input  logic          halt_i,
    input  logic          fetch_ready_i,
    output logic [AW-3:0] pc_o,
    output logic          fetch_valid_o,
    output logic [AW-3:0] epc_o,
    output logic          halted_o
);

    localparam int          PW     = AW - 2;
    localparam logic [PW-1:0] RESET_W = RESET_VEC[AW-1:2];
    localparam logic [PW-1:0] TRAP_W  = TRAP_VEC[AW-1:2];

    pc_state_e     state_q, state_d;
    logic [PW-1:0] pc_q, pc_d;
    logic [PW-1:0] epc;
    logic          eret_act;

`ifdef PC_GEN_EPC_EN
    assign eret_act = eret_i;
`else
    logic unused_eret;
    assign unused_eret = eret_i;
    assign eret_act    = 1'b0;
`endif

    // Trap is honoured from every state, so it sits outside the per-state cases.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (trap_i) begin
            pc_d    = TRAP_W;
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_BOOT: state_d = ST_RUN;
                ST_RUN: begin
                    if (eret_act) begin
                        pc_d = epc;
                    end else if (br_valid_i) begin
                        pc_d = br_target_i;
                    end else if (halt_i) begin
                        state_d = ST_HALT;
                    end else if (!stall_i && fetch_ready_i) begin
                        pc_d = pc_q + PW'(1);
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_BOOT;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_W;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    pc_gen_epc #(.PW(PW)) u_epc (
        .CLK    (CLK),
        .RST    (RST),
        .load_i (trap_i),
        .pc_i   (pc_q),
        .epc_o  (epc)
    );

    assign pc_o          = pc_q;
    assign epc_o         = epc;
    assign fetch_valid_o = (state_q == ST_RUN);
    assign halted_o      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a behavioural PC model.
module tb_pc_gen;

    localparam int AW = 32;
    localparam int PW = AW - 2;
    localparam logic [PW-1:0] RST_W  = 30'h0000_0C00;
    localparam logic [PW-1:0] TRAP_W = 30'h0000_1060;
`ifdef PC_GEN_EPC_EN
    localparam bit EPC_EN = 1'b1;
`else
    localparam bit EPC_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          stall_i = 0, br_valid_i = 0, trap_i = 0, eret_i = 0, halt_i = 0;
    logic          fetch_ready_i = 0;
    logic [PW-1:0] br_target_i = '0;
    logic [PW-1:0] pc_o, epc_o;
    logic          fetch_valid_o, halted_o;

    always #5 CLK = ~CLK;

    pc_gen #(.AW(AW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .stall_i       (stall_i),
        .br_valid_i    (br_valid_i),
        .br_target_i   (br_target_i),
        .trap_i        (trap_i),
        .eret_i        (eret_i),
        .halt_i        (halt_i),
        .fetch_ready_i (fetch_ready_i),
        .pc_o          (pc_o),
        .fetch_valid_o (fetch_valid_o),
        .epc_o         (epc_o),
        .halted_o      (halted_o)
    );

    // Model: mode 0 = just out of reset, 1 = fetching, 2 = halted
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [PW-1:0] m_pc, m_epc;
    int            m_mode;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"}, 64'(pc_o), 64'(m_pc));
        chk({tag, ".epc"}, 64'(epc_o), 64'(m_epc));
        chk({tag, ".fv"}, 64'(fetch_valid_o), 64'(m_mode == 1));
        chk({tag, ".halted"}, 64'(halted_o), 64'(m_mode == 2));
    endtask

    task automatic model_step();
        longint nxt;
        if (trap_i) begin
            if (EPC_EN) m_epc = m_pc;
            m_pc   = TRAP_W;
            m_mode = 1;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (EPC_EN && eret_i) m_pc = m_epc;
            else if (br_valid_i) m_pc = br_target_i;
            else if (halt_i) m_mode = 2;
            else if (!stall_i && fetch_ready_i) begin
                nxt  = (longint'(m_pc) + 1) % (longint'(1) << PW);
                m_pc = PW'(nxt);
            end
        end
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge CLK);
        #1;
        check_all(tag);
    endtask

    task automatic idle();
        stall_i = 0; br_valid_i = 0; trap_i = 0; eret_i = 0; halt_i = 0;
        fetch_ready_i = 0; br_target_i = '0;
    endtask

    // Reset is asserted between edges to exercise its asynchronous action.
    task automatic do_reset(input string tag);
        RST = 1'b1;
        #1;
        m_pc = RST_W; m_epc = '0; m_mode = 0;
        check_all({tag, ".async"});
        @(posedge CLK);
        #1;
        check_all({tag, ".held"});
        RST = 1'b0;
        idle();
        #1;
        check_all({tag, ".boot"});
    endtask

    initial begin
        m_pc = RST_W; m_epc = '0; m_mode = 0;
        @(posedge CLK);
        #1;
        do_reset("reset");
        cycle("boot_to_run");
        chk("reset_vec", 64'(pc_o), 64'h0C00);
        chk("run_fv", 64'(fetch_valid_o), 64'd1);

        fetch_ready_i = 1; cycle("seq1");
        chk("seq1_lit", 64'(pc_o), 64'h0C01);
        fetch_ready_i = 0; cycle("seq2");
        chk("seq2_lit", 64'(pc_o), 64'h0C01);
        fetch_ready_i = 1; cycle("seq3");
        chk("seq3_lit", 64'(pc_o), 64'h0C02);
        repeat (3) cycle("seq_more");

        trap_i = 1; br_valid_i = 1; br_target_i = 30'h2000; fetch_ready_i = 0;
        cycle("trap_br");
        chk("trap_lit", 64'(pc_o), 64'h1060);
        chk("epc_lit", 64'(epc_o), EPC_EN ? 64'h0C05 : 64'h0);
        idle(); eret_i = 1;
        cycle("eret");
        chk("eret_lit", 64'(pc_o), EPC_EN ? 64'h0C05 : 64'h1060);

        idle(); stall_i = 1; fetch_ready_i = 1; br_valid_i = 1; br_target_i = 30'h2000;
        cycle("stall_br");
        chk("stall_br_lit", 64'(pc_o), 64'h2000);
        idle(); stall_i = 1; fetch_ready_i = 1;
        cycle("stall_hold");

        idle(); br_valid_i = 1; br_target_i = 30'h3FFF_FFFF;
        cycle("br_top");
        idle(); fetch_ready_i = 1;
        cycle("wrap");
        chk("wrap_lit", 64'(pc_o), 64'h0);

        idle(); halt_i = 1; fetch_ready_i = 1;
        cycle("halt");
        chk("halt_lit", 64'(halted_o), 64'd1);
        idle(); br_valid_i = 1; br_target_i = 30'h1234; eret_i = 1; fetch_ready_i = 1;
        cycle("halt_ign1");
        cycle("halt_ign2");
        idle(); trap_i = 1;
        cycle("halt_trap");
        chk("halt_trap_lit", 64'(pc_o), 64'h1060);
        idle();
        cycle("after_trap");

        br_valid_i = 1; br_target_i = 30'h0ABC; halt_i = 1;
        do_reset("mid_reset");
        cycle("mid_boot");

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd_reset");
            end else begin
                trap_i        = ($urandom_range(0, 31) == 0);
                eret_i        = ($urandom_range(0, 15) == 0);
                br_valid_i    = ($urandom_range(0, 7) == 0);
                halt_i        = ($urandom_range(0, 39) == 0);
                stall_i       = ($urandom_range(0, 3) == 0);
                fetch_ready_i = ($urandom_range(0, 3) != 0);
                br_target_i   = ($urandom_range(0, 3) == 0) ? 30'h3FFF_FFFE + PW'($urandom_range(0, 1))
                                                            : PW'($urandom);
                cycle("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter AW, default 32, byte-address width; PC held as word address [AW-1:2].
REQ-002 SHALL have parameter RESET_VEC, default 32'h0000_3000, byte address loaded on reset.
REQ-003 SHALL have parameter TRAP_VEC, default 32'h0000_4180, byte address taken on trap.
REQ-004 SHALL have port CLK  in  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port RST  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port stall_i  in  1  pipeline stall; hold PC.
REQ-007 SHALL have port br_valid_i  in  1  branch/jump redirect request.
REQ-008 SHALL have port br_target_i  in  AW-2  redirect word address.
REQ-009 SHALL have port trap_i  in  1  exception/interrupt request.
REQ-010 SHALL have port eret_i  in  1  return-from-exception request.
REQ-011 SHALL have port halt_i  in  1  enter halt state.
REQ-012 SHALL have port fetch_ready_i  in  1  instruction memory accepts pc_o.
REQ-013 SHALL have port pc_o  out  AW-2  current fetch word address.
REQ-014 SHALL have port fetch_valid_o  out  1  pc_o is a valid fetch request.
REQ-015 SHALL have port epc_o  out  AW-2  saved exception PC.
REQ-016 SHALL have port halted_o  out  1  high while in HALT.

Function
REQ-017 SHALL implement FSM states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-018 SHALL drive fetch_valid_o=1 only in RUN; 0 in BOOT and HALT.
REQ-019 SHALL apply next-PC priority in RUN: trap_i > eret_i > br_valid_i > halt_i > stall_i > sequential.
REQ-020 SHALL on trap_i load pc_o<=TRAP_VEC[AW-1:2] and epc_o<=pc_o, in any state including HALT (HALT->RUN).
REQ-021 SHALL on eret_i (no trap_i) load pc_o<=epc_o.
REQ-022 SHALL on br_valid_i load pc_o<=br_target_i regardless of stall_i or fetch_ready_i.
REQ-023 SHALL on halt_i (no higher request) hold pc_o and enter HALT next cycle; br_valid_i, eret_i, halt_i ignored in HALT.
REQ-024 SHALL advance pc_o<=pc_o+1 only when fetch_valid_o & fetch_ready_i & !stall_i; otherwise hold.
REQ-025 SHALL wrap increment modulo 2^(AW-2) (all-ones -> 0), no flag.
REQ-026 SHALL have 1-cycle latency from any request to updated pc_o; no combinational input-to-pc_o path.

Reset
REQ-027 SHALL on RST set pc_o=RESET_VEC[AW-1:2], epc_o=0, state=BOOT, fetch_valid_o=0, halted_o=0, immediately and asynchronously.
REQ-028 SHALL abandon any in-progress redirect or halt when RST asserts mid-operation.

Configuration
REQ-029 SHALL with PC_GEN_EPC_EN defined implement epc register and eret_i behaviour per REQ-020/021.
REQ-030 SHALL without PC_GEN_EPC_EN tie epc_o to 0 and ignore eret_i; trap still vectors to TRAP_VEC.

Structure
REQ-031 SHALL place state enum, RESET_VEC/TRAP_VEC defaults in shared package pc_gen_pkg.
REQ-032 SHALL keep logic in one module; optional sub-module pc_gen_epc holds the epc register.

Verification
REQ-033 SHALL test reset: RST pulse -> pc_o=0xC00, fetch_valid_o=0 one cycle, then 1.
REQ-034 SHALL test sequential/handshake: fetch_ready_i toggling 1,0,1 from 0xC00 -> pc_o 0xC01, 0xC01, 0xC02.
REQ-035 SHALL test priority: trap_i+br_valid_i(target 0x2000) same cycle at pc 0xC05 -> pc_o=0x1060, epc_o=0xC05; eret_i -> pc_o=0xC05.
REQ-036 SHALL test stall vs branch: stall_i=1 with br_valid_i target 0x2000 -> pc_o=0x2000 next cycle.
REQ-037 SHALL test wrap: pc_o=0x3FFFFFFF, ready -> pc_o=0.
REQ-038 SHALL test halt: halt_i -> halted_o=1, fetch_valid_o=0, br_valid_i ignored; trap_i -> pc_o=0x1060, RUN.
